// File: rtl/aib_axi_link_init_seq.sv
// Bring-up sequencer for the AIB-to-AXI leader channel (clk_wr domain).
// Optional build macro AIB_INIT_RETRY_EN: failures retry through RST_HOLD up to MAX_RETRY times.
module aib_axi_link_init_seq #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 4096,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk_wr,
  input  logic       rst_wr_n,
  input  logic       i_start,
  input  logic       i_clear,
  input  logic       i_device_detect,
  input  logic       i_fs_mac_rdy,
  input  logic       i_rx_align_done,
  output logic       o_ns_adapter_rstn,
  output logic       o_ns_mac_rdy,
  output logic       o_dcc_dll_lock_req,
  output logic       o_axi_en,
  output logic       o_link_up,
  output logic       o_error,
  output logic [2:0] o_err_code,
  output logic [2:0] o_state,
  output logic [1:0] o_retry_cnt
);

  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
`ifdef AIB_INIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DETECT   = 3'd1,
    ST_RST_HOLD = 3'd2,
    ST_MAC_RDY  = 3'd3,
    ST_ALIGN    = 3'd4,
    ST_LINK_UP  = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  localparam int NSYNC = 3;

  logic [NSYNC-1:0] async_in;
  logic [NSYNC-1:0] sync_vec;
  logic             s_device_detect;
  logic             s_fs_mac_rdy;
  logic             s_rx_align_done;

  assign async_in = {i_rx_align_done, i_fs_mac_rdy, i_device_detect};

  // Two-flop synchroniser per far-side status line.
  generate
    for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_vec[gi] = sync_reg;
    end
  endgenerate

  assign s_device_detect = sync_vec[0];
  assign s_fs_mac_rdy    = sync_vec[1];
  assign s_rx_align_done = sync_vec[2];

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic [2:0]      code_next;
  logic [1:0]      retry_next;
  logic            fail;
  logic [2:0]      fail_code;
  logic            timed_out;
  logic            drive_next;

  assign timed_out = (cnt_reg == TO_LAST);

  always_comb begin
    state_next = state_reg;
    code_next  = o_err_code;
    retry_next = o_retry_cnt;
    fail       = 1'b0;
    fail_code  = 3'd0;

    if (state_reg != ST_ERROR && !i_start) begin
      state_next = ST_IDLE;
      code_next  = 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE:     state_next = ST_DETECT;
        ST_DETECT: begin
          if (s_device_detect)  state_next = ST_RST_HOLD;
          else if (timed_out) begin fail = 1'b1; fail_code = 3'd1; end
        end
        ST_RST_HOLD: if (cnt_reg == HOLD_LAST) state_next = ST_MAC_RDY;
        ST_MAC_RDY: begin
          if (s_fs_mac_rdy)     state_next = ST_ALIGN;
          else if (timed_out) begin fail = 1'b1; fail_code = 3'd2; end
        end
        ST_ALIGN: begin
          if (s_rx_align_done)  state_next = ST_LINK_UP;
          else if (timed_out) begin fail = 1'b1; fail_code = 3'd3; end
        end
        ST_LINK_UP: begin
          if (!s_fs_mac_rdy || !s_rx_align_done) begin
            fail      = 1'b1;
            fail_code = 3'd4;
          end
        end
        ST_ERROR: begin
          if (i_clear) begin
            state_next = ST_IDLE;
            code_next  = 3'd0;
          end
        end
        default:     state_next = ST_IDLE;
      endcase
    end

    // The last cause is kept even while a retry is in flight.
    if (fail) begin
      code_next = fail_code;
      if (RETRY_EN && (o_retry_cnt < RETRY_MAX)) begin
        retry_next = o_retry_cnt + 2'd1;
        state_next = ST_RST_HOLD;
      end else begin
        state_next = ST_ERROR;
      end
    end

    if (state_next == ST_IDLE || state_next == ST_LINK_UP) retry_next = 2'd0;

    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (state_reg == ST_DETECT || state_reg == ST_RST_HOLD ||
                 state_reg == ST_MAC_RDY || state_reg == ST_ALIGN) begin
      cnt_next = cnt_reg + 1'b1;
    end else begin
      cnt_next = '0;
    end

    drive_next = (state_next == ST_MAC_RDY) || (state_next == ST_ALIGN) ||
                 (state_next == ST_LINK_UP);
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_reg          <= ST_IDLE;
      cnt_reg            <= '0;
      o_ns_adapter_rstn  <= 1'b0;
      o_ns_mac_rdy       <= 1'b0;
      o_dcc_dll_lock_req <= 1'b0;
      o_axi_en           <= 1'b0;
      o_link_up          <= 1'b0;
      o_error            <= 1'b0;
      o_err_code         <= 3'd0;
      o_retry_cnt        <= 2'd0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      o_ns_adapter_rstn  <= drive_next;
      o_ns_mac_rdy       <= drive_next;
      o_dcc_dll_lock_req <= drive_next;
      o_axi_en           <= (state_next == ST_LINK_UP);
      o_link_up          <= (state_next == ST_LINK_UP);
      o_error            <= (state_next == ST_ERROR);
      o_err_code         <= code_next;
      o_retry_cnt        <= retry_next;
    end
  end

  assign o_state = state_reg;

endmodule

// File: tb/tb_aib_axi_link_init_seq.sv
// Self-checking bench for aib_axi_link_init_seq: directed bring-up cases plus randomized
// schedules compared every cycle against a phase/elapsed-time reference model.
module tb_aib_axi_link_init_seq;

  localparam int RST_CYCLES = 16;
  localparam int TIMEOUT    = 64;
  localparam int MAX_RETRY  = 3;

  logic       clk_wr = 1'b0;
  logic       rst_wr_n = 1'b1;
  logic       i_start = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_device_detect = 1'b0;
  logic       i_fs_mac_rdy = 1'b0;
  logic       i_rx_align_done = 1'b0;
  logic       o_ns_adapter_rstn;
  logic       o_ns_mac_rdy;
  logic       o_dcc_dll_lock_req;
  logic       o_axi_en;
  logic       o_link_up;
  logic       o_error;
  logic [2:0] o_err_code;
  logic [2:0] o_state;
  logic [1:0] o_retry_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk_wr = ~clk_wr;

  aib_axi_link_init_seq #(
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk_wr            (clk_wr),
    .rst_wr_n          (rst_wr_n),
    .i_start           (i_start),
    .i_clear           (i_clear),
    .i_device_detect   (i_device_detect),
    .i_fs_mac_rdy      (i_fs_mac_rdy),
    .i_rx_align_done   (i_rx_align_done),
    .o_ns_adapter_rstn (o_ns_adapter_rstn),
    .o_ns_mac_rdy      (o_ns_mac_rdy),
    .o_dcc_dll_lock_req(o_dcc_dll_lock_req),
    .o_axi_en          (o_axi_en),
    .o_link_up         (o_link_up),
    .o_error           (o_error),
    .o_err_code        (o_err_code),
    .o_state           (o_state),
    .o_retry_cnt       (o_retry_cnt)
  );

  logic [13:0] dut_outs;
  assign dut_outs = {o_ns_adapter_rstn, o_ns_mac_rdy, o_dcc_dll_lock_req, o_axi_en,
                     o_link_up, o_error, o_err_code, o_state, o_retry_cnt};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0..6 = idle, detect, reset hold, mac ready, align, up, error.
  // 'spent' is the number of clock edges already evaluated in the current phase.
  int         m_phase, m_spent, m_code, m_retries;
  logic [2:0] m_seen1, m_seen2;   // {align, fs, detect} as sampled 1 and 2 edges ago

  task automatic model_reset();
    m_phase = 0; m_spent = 0; m_code = 0; m_retries = 0;
    m_seen1 = 3'b000; m_seen2 = 3'b000;
  endtask

  task automatic fail_to(input int cause, inout int nph);
    m_code = cause;
`ifdef AIB_INIT_RETRY_EN
    if (m_retries < MAX_RETRY) begin
      m_retries = m_retries + 1;
      nph = 2;
    end else begin
      nph = 6;
    end
`else
    nph = 6;
`endif
  endtask

  task automatic model_step();
    logic det, fs, al;
    int   nph, now;
    det = m_seen2[0]; fs = m_seen2[1]; al = m_seen2[2];
    m_seen2 = m_seen1;
    m_seen1 = {i_rx_align_done, i_fs_mac_rdy, i_device_detect};
    nph = m_phase;
    now = m_spent + 1;
    if (m_phase != 6 && !i_start) begin
      nph = 0;
      m_code = 0;
    end else begin
      case (m_phase)
        0: nph = 1;
        1: if (det) nph = 2; else if (now == TIMEOUT) fail_to(1, nph);
        2: if (now == RST_CYCLES) nph = 3;
        3: if (fs) nph = 4; else if (now == TIMEOUT) fail_to(2, nph);
        4: if (al) nph = 5; else if (now == TIMEOUT) fail_to(3, nph);
        5: if (!(fs && al)) fail_to(4, nph);
        default: if (i_clear) begin nph = 0; m_code = 0; end
      endcase
    end
    if (nph == 0 || nph == 5) m_retries = 0;
    m_spent = (nph == m_phase) ? now : 0;
    m_phase = nph;
  endtask

  function automatic logic [13:0] model_outs();
    logic drive;
    drive = (m_phase >= 3) && (m_phase <= 5);
    return {drive, drive, drive, m_phase == 5, m_phase == 5, m_phase == 6,
            3'(m_code), 3'(m_phase), 2'(m_retries)};
  endfunction

  task automatic tick();
    @(posedge clk_wr);
    model_step();
    @(negedge clk_wr);
    chk("outs", int'(dut_outs), int'(model_outs()));
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(o_state) != st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(o_state), st);
  endtask

  task automatic recover();
    i_start = 1'b0; i_clear = 1'b1;
    i_device_detect = 1'b0; i_fs_mac_rdy = 1'b0; i_rx_align_done = 1'b0;
    tick();
    i_clear = 1'b0;
    tick();
    chk("recover_idle", int'(o_state), 0);
  endtask

  int n;
  int t_det, t_fs, t_al, t_drop, t_abort;
  int max_retry_seen;

  initial begin
    model_reset();
    #2 rst_wr_n = 1'b0;
    repeat (3) @(negedge clk_wr);
    chk("reset_outs", int'(dut_outs), 0);
    rst_wr_n = 1'b1;
    tick();

    // Nominal bring-up and hold length
    i_start = 1'b1; i_device_detect = 1'b1;
    wait_state(2, 20, "enter_rst_hold");
    n = 0;
    while (o_state == 3'd2 && n < 100) begin tick(); n++; end
    chk("rst_hold_len", n, RST_CYCLES);
    chk("rstn_after_hold", int'(o_ns_adapter_rstn), 1);
    repeat (14) tick();
    i_fs_mac_rdy = 1'b1;
    repeat (20) tick();
    i_rx_align_done = 1'b1;
    wait_state(5, 10, "nominal_link_up");
    chk("nominal_axi_en", int'(o_axi_en), 1);
    chk("nominal_code", int'(o_err_code), 0);

    // Link drop: three edges from input fall to o_axi_en fall
    i_fs_mac_rdy = 1'b0;
    n = 0;
    while (o_axi_en && n < 10) begin tick(); n++; end
    chk("drop_latency", n, 3);
    chk("drop_code", int'(o_err_code), 4);
`ifndef AIB_INIT_RETRY_EN
    chk("drop_state", int'(o_state), 6);
`else
    chk("drop_retry_state", int'(o_state), 2);
    chk("drop_retry_cnt", int'(o_retry_cnt), 1);
`endif
    recover();

`ifndef AIB_INIT_RETRY_EN
    // Align timeout then clear
    i_start = 1'b1; i_device_detect = 1'b1; i_fs_mac_rdy = 1'b1;
    wait_state(4, 200, "enter_align");
    n = 0;
    while (o_state == 3'd4 && n < 200) begin tick(); n++; end
    chk("align_wait_len", n, TIMEOUT);
    chk("align_to_error", int'(o_error), 1);
    chk("align_to_code", int'(o_err_code), 3);
    chk("align_to_rstn", int'(o_ns_adapter_rstn), 0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("clear_state", int'(o_state), 0);
    chk("clear_code", int'(o_err_code), 0);
    recover();
`else
    // fs_mac_rdy never arrives: retries exhaust, then ERROR with code 2
    i_start = 1'b1; i_device_detect = 1'b1;
    max_retry_seen = 0;
    n = 0;
    while (o_state != 3'd6 && n < 1000) begin
      tick();
      n++;
      if (int'(o_retry_cnt) > max_retry_seen) max_retry_seen = int'(o_retry_cnt);
    end
    chk("retry_error_state", int'(o_state), 6);
    chk("retry_max_seen", max_retry_seen, MAX_RETRY);
    chk("retry_code", int'(o_err_code), 2);
    recover();
`endif

    // Align rises exactly on the timeout cycle: success wins
    i_start = 1'b1; i_device_detect = 1'b1; i_fs_mac_rdy = 1'b1;
    wait_state(4, 200, "race_enter_align");
    repeat (TIMEOUT - 3) tick();
    i_rx_align_done = 1'b1;
    repeat (3) tick();
    chk("race_state", int'(o_state), 5);
    chk("race_error", int'(o_error), 0);
    recover();

    // Abort during RST_HOLD
    i_start = 1'b1; i_device_detect = 1'b1;
    wait_state(2, 20, "abort_enter_hold");
    i_start = 1'b0;
    tick();
    chk("abort_idle", int'(o_state), 0);
    recover();

    // Asynchronous reset while LINK_UP
    i_start = 1'b1; i_device_detect = 1'b1; i_fs_mac_rdy = 1'b1; i_rx_align_done = 1'b1;
    wait_state(5, 200, "rst_enter_up");
    rst_wr_n = 1'b0;
    #1;
    chk("async_rst_outs", int'(dut_outs), 0);
    model_reset();
    repeat (2) @(negedge clk_wr);
    rst_wr_n = 1'b1;
    wait_state(5, 200, "rst_restart_up");
    recover();

    // Randomized schedules
    for (int sc = 0; sc < 24; sc++) begin
      t_det   = $urandom_range(0, 90);
      t_fs    = $urandom_range(0, 110);
      t_al    = $urandom_range(0, 130);
      t_drop  = ($urandom_range(0, 2) == 0) ? $urandom_range(100, 220) : 1000;
      t_abort = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 200) : 1000;
      for (int k = 0; k < 240; k++) begin
        i_start         = (k < t_abort);
        i_device_detect = (k >= t_det);
        i_fs_mac_rdy    = (k >= t_fs) && (k < t_drop);
        i_rx_align_done = (k >= t_al);
        i_clear         = ($urandom_range(0, 15) == 0);
        tick();
      end
      recover();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
